// File: rtl/mem_access_unit.sv
// Memory stage: performs execute-stage loads/stores over a req/ack word bus
// and passes non-memory results through to write-back.
`ifndef WIDTH
`define WIDTH 32
`endif
`ifndef LW
`define LW 6'h23
`endif
`ifndef SW
`define SW 6'h2B
`endif
`ifndef LH
`define LH 6'h21
`endif
`ifndef SH
`define SH 6'h29
`endif
`ifndef LD
`define LD 6'h20
`endif
`ifndef SD
`define SD 6'h28
`endif

module mem_access_unit #(
   parameter int WIDTH   = `WIDTH,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] instruction_in,
   input  logic [WIDTH-3:0] progcounter_in,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] dataC,
   output logic             IsStall,
   output logic             out_valid,
   output logic [WIDTH-1:0] instruction_out,
   output logic [WIDTH-3:0] progcounter_out,
   output logic [WIDTH-1:0] wb_data,
   output logic             misalign,
   output logic             bus_err,
   output logic             mem_req,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_addr,
   output logic [3:0]       mem_be,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ack
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_t;
   typedef enum logic [1:0] {SzByte, SzHalf, SzWord} size_t;

   state_t     state;
   size_t      size_q;
   logic [1:0] lane_q;
   logic       load_q;
   logic [7:0] cnt;

   logic [5:0]       opcode;
   logic             is_mem;
   logic             is_load;
   size_t            size_n;
   logic             mis;
   logic [3:0]       be_n;
   logic [WIDTH-1:0] wdata_n;
   logic [WIDTH-1:0] ld_ext;
   logic [15:0]      half_sel;
   logic [7:0]       byte_sel;

   assign opcode  = instruction_in[WIDTH-1:WIDTH-6];
   assign IsStall = (state != StIdle);

   always_comb begin
      is_mem  = 1'b1;
      is_load = 1'b0;
      size_n  = SzWord;
      unique case (opcode)
         `LW:     begin is_load = 1'b1; size_n = SzWord; end
         `SW:     size_n = SzWord;
         `LH:     begin is_load = 1'b1; size_n = SzHalf; end
         `SH:     size_n = SzHalf;
         `LD:     begin is_load = 1'b1; size_n = SzByte; end
         `SD:     size_n = SzByte;
         default: is_mem = 1'b0;
      endcase
   end

   always_comb begin
      mis     = 1'b0;
      be_n    = 4'b1111;
      wdata_n = dataC;
      unique case (size_n)
         SzWord: mis = (addr[1:0] != 2'b00);
         SzHalf: begin
            mis     = addr[0];
            be_n    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{dataC[15:0]}};
         end
         default: begin
            be_n    = 4'b0001 << addr[1:0];
            wdata_n = {4{dataC[7:0]}};
         end
      endcase
   end

   // Lane select and sign extension of the returned word
   always_comb begin
      half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
      unique case (size_q)
         SzWord:  ld_ext = mem_rdata;
         SzHalf:  ld_ext = {{(WIDTH-16){half_sel[15]}}, half_sel};
         default: ld_ext = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= StIdle;
         size_q          <= SzWord;
         lane_q          <= 2'b00;
         load_q          <= 1'b0;
         cnt             <= 8'd0;
         out_valid       <= 1'b0;
         instruction_out <= '0;
         progcounter_out <= '0;
         wb_data         <= '0;
         misalign        <= 1'b0;
         bus_err         <= 1'b0;
         mem_req         <= 1'b0;
         mem_we          <= 1'b0;
         mem_addr        <= '0;
         mem_be          <= 4'b0000;
         mem_wdata       <= '0;
      end else begin
         unique case (state)
            StIdle: begin
               if (in_valid) begin
                  instruction_out <= instruction_in;
                  progcounter_out <= progcounter_in;
                  if (!is_mem) begin
                     wb_data   <= dataC;
                     out_valid <= 1'b1;
                     state     <= StResp;
                  end else if (mis) begin
                     wb_data   <= '0;
                     misalign  <= 1'b1;
                     out_valid <= 1'b1;
                     state     <= StResp;
                  end else begin
                     mem_req   <= 1'b1;
                     mem_we    <= ~is_load;
                     mem_addr  <= {addr[WIDTH-1:2], 2'b00};
                     mem_be    <= be_n;
                     mem_wdata <= wdata_n;
                     size_q    <= size_n;
                     lane_q    <= addr[1:0];
                     load_q    <= is_load;
                     cnt       <= 8'd0;
                     state     <= StAccess;
                  end
               end
            end
            StAccess: begin
               // Ack takes priority over a coincident timeout
               if (mem_ack) begin
                  mem_req   <= 1'b0;
                  wb_data   <= load_q ? ld_ext : '0;
                  out_valid <= 1'b1;
                  state     <= StResp;
               end else if (9'(cnt) + 9'd1 == 9'(TIMEOUT)) begin
                  mem_req   <= 1'b0;
                  bus_err   <= 1'b1;
                  wb_data   <= '0;
                  out_valid <= 1'b1;
                  state     <= StResp;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            StResp: begin
               out_valid <= 1'b0;
               misalign  <= 1'b0;
               bus_err   <= 1'b0;
               state     <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage that consumes the execute stage's load/store results (instruction, address, store data) and performs the transfer on a word-wide data-memory bus with a req/ack handshake.
- Produces load write-back data and passes non-memory instructions through.
- Asserts IsStall back to execute while a bus transfer is outstanding.
- Sits between the execution unit and write-back.

Parameters:
- WIDTH, 32, datapath width; equals `WIDTH.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting (1..255).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  execute stage presents an instruction
- instruction_in  in  WIDTH  instruction; opcode is [31:26]
- progcounter_in  in  WIDTH-2  PC of the instruction
- addr  in  WIDTH  effective byte address from execute
- dataC  in  WIDTH  store data, or ALU result for non-memory ops
- IsStall  out  1  high while busy; upstream holds its inputs
- out_valid  out  1  one-cycle pulse when a result is ready
- instruction_out  out  WIDTH  registered copy of the accepted instruction
- progcounter_out  out  WIDTH-2  registered copy of the accepted PC
- wb_data  out  WIDTH  load data, or passed-through dataC
- misalign  out  1  valid with out_valid; access was not performed
- bus_err  out  1  valid with out_valid; access timed out
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  WIDTH  word address ({addr[WIDTH-1:2],2'b00})
- mem_be  out  4  byte-lane enables
- mem_wdata  out  WIDTH  lane-replicated store data
- mem_rdata  in  WIDTH  read data, valid when mem_ack is high
- mem_ack  in  1  one-cycle completion strobe

Behaviour:
- Reset: every output is 0 and the state is IDLE. Reset has priority over all events, including mid-transfer: mem_req drops at that edge and no out_valid is issued.
- Sizes:
  - `LW/`SW: 32-bit, requires addr[1:0]=0.
  - `LH/`SH: 16-bit, requires addr[0]=0, lane = addr[1].
  - `LD/`SD: 8-bit, lane = addr[1:0].
- Loads sign-extend to WIDTH. Lane 0 is bits [7:0] (little-endian).
- Store data is replicated across the lanes: byte x4, half x2.
- mem_be:
  - word: 4'b1111.
  - half: 4'b0011 or 4'b1100.
  - byte: one-hot 1<<addr[1:0].
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If in_valid is sampled high, latch instruction/PC/addr/dataC into instruction_out/progcounter_out and internal registers.
  - Non-memory opcode: go to RESP with wb_data=dataC. Latency is 1 cycle.
  - Misaligned memory opcode: go to RESP with misalign=1, wb_data=0, and no bus activity.
  - Aligned memory opcode: go to ACCESS with mem_req=1 and the bus fields driven from the next cycle.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata stay stable until mem_ack is sampled high.
  - On ack: mem_req falls at the same edge. A load captures the extended lane into wb_data; a store sets wb_data=0. Go to RESP.
  - An 8-bit counter, cleared on entry, increments each cycle without ack. When it reaches TIMEOUT, drop mem_req, set bus_err=1 and wb_data=0, and go to RESP.
  - If ack arrives in the same cycle the count hits TIMEOUT, ack wins.
- RESP: out_valid=1 for exactly one cycle, then return to IDLE.
  - out_valid, misalign and bus_err clear on leaving RESP.
  - wb_data and instruction_out hold their values until the next acceptance.
- IsStall = (state != IDLE). in_valid is ignored unless in IDLE, so back-to-back instructions are accepted at best every 2 cycles.
- mem_ack outside ACCESS is ignored.
- mem_rdata is sampled only on the ack edge.
- `NOP/`HALT/unknown opcodes are treated as non-memory.

Test Plan:
- Reset with rst=1 for 2 cycles -> all outputs are 0, IsStall=0, and mem_ack pulses are ignored.
- `LW, addr=0x104; mem_ack asserted 3 cycles after mem_req with mem_rdata=0xDEADBEEF:
  - mem_addr=0x104, mem_be=1111, mem_we=0.
  - IsStall high through ACCESS.
  - out_valid one cycle after the ack, with wb_data=0xDEADBEEF.
- `LD addr=0x203 with rdata=0x80000000 -> wb_data=0xFFFFFF80.
- `LH addr=0x202 with rdata=0x7FFF0000 -> wb_data=0x00007FFF.
- `SH addr=0x12 with dataC=0x0000ABCD -> mem_we=1, mem_addr=0x10, mem_be=1100, mem_wdata=0xABCDABCD; wb_data=0.
- `LW addr=0x101 -> misalign=1 with out_valid, mem_req never asserted.
- `ADD with dataC=5 -> out_valid the next cycle, wb_data=5, no bus activity.
- `LW with mem_ack never asserted and TIMEOUT=4 -> mem_req high for 4 cycles, then bus_err=1 and out_valid=1.
- Repeat with rst asserted during ACCESS -> mem_req=0 the next cycle, no out_valid, and a late ack is ignored.
